// File: rtl/line_drawer_pkg.sv
// Shared types and width constants for the Bresenham line drawer.
package line_drawer_pkg;

    localparam int COORD_W_DEF = 11;
    // err and e2 carry this many bits beyond COORD_W, so full-range lines cannot overflow.
    localparam int ERR_EXTRA_W = 3;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/line_drawer.sv
// Emits one pixel of a straight line per clock (integer Bresenham, all octants).
// Endpoints are captured on the first edge after reset; finished rises after the end pixel.
module line_drawer
    import line_drawer_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               finished
);

    localparam int DW = COORD_W + 1;
    localparam int EW = COORD_W + ERR_EXTRA_W;

    state_t               state_q;
    logic                 finished_q;
    logic [COORD_W-1:0]   px_q, py_q, px_d, py_d;
    logic [COORD_W-1:0]   x1_q, y1_q;
    logic signed [EW-1:0] err_q, err_d;
    logic signed [EW-1:0] dx_q, dy_q;
    logic                 sx_neg_q, sy_neg_q;

    logic signed [DW-1:0] x0_s, y0_s, x1_s, y1_s;
    logic signed [DW-1:0] adx, ady;
    logic signed [EW-1:0] dx_init, dy_init, e2;
    logic                 step_x, step_y, at_end;

    assign x0_s = $signed({1'b0, x0});
    assign y0_s = $signed({1'b0, y0});
    assign x1_s = $signed({1'b0, x1});
    assign y1_s = $signed({1'b0, y1});

    always_comb begin
        adx     = (x1_s >= x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
        ady     = (y1_s >= y0_s) ? (y1_s - y0_s) : (y0_s - y1_s);
        dx_init = $signed({{(EW-DW){1'b0}}, adx});
        dy_init = -$signed({{(EW-DW){1'b0}}, ady});
    end

    // Both steps are decided from the same e2, so a diagonal move updates err twice.
    always_comb begin
        e2     = $signed({err_q[EW-2:0], 1'b0});
        step_x = (e2 >= dy_q);
        step_y = (e2 <= dx_q);
        at_end = (px_q == x1_q) && (py_q == y1_q);
        err_d  = err_q;
        px_d   = px_q;
        py_d   = py_q;
        if (step_x) begin
            err_d = err_d + dy_q;
            px_d  = sx_neg_q ? (px_q - COORD_W'(1)) : (px_q + COORD_W'(1));
        end
        if (step_y) begin
            err_d = err_d + dx_q;
            py_d  = sy_neg_q ? (py_q - COORD_W'(1)) : (py_q + COORD_W'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOAD;
            finished_q <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            err_q      <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            sx_neg_q   <= 1'b0;
            sy_neg_q   <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    px_q     <= x0;
                    py_q     <= y0;
                    x1_q     <= x1;
                    y1_q     <= y1;
                    dx_q     <= dx_init;
                    dy_q     <= dy_init;
                    err_q    <= dx_init + dy_init;
                    sx_neg_q <= !(x0 < x1);
                    sy_neg_q <= !(y0 < y1);
                    state_q  <= DRAW;
                end
                DRAW: begin
                    if (at_end) begin
                        state_q    <= DONE;
                        finished_q <= 1'b1;
                    end else begin
                        err_q <= err_d;
                        px_q  <= px_d;
                        py_q  <= py_d;
                    end
                end
                DONE: state_q <= DONE;
                default: state_q <= LOAD;
            endcase
        end
    end

    // In LOAD the start point is shown straight from the inputs, even while reset is held.
    assign x        = (state_q == LOAD) ? x0 : px_q;
    assign y        = (state_q == LOAD) ? y0 : py_q;
    assign finished = finished_q;

endmodule

// File: tb/tb_line_drawer.sv
// Scoreboard bench: stimulus pushes per-cycle expected pixels, a negedge monitor pops and compares.
module tb_line_drawer;

    localparam int CW = 11;

    logic          clk;
    logic          reset;
    logic [CW-1:0] x0, y0, x1, y1;
    logic [CW-1:0] x, y;
    logic          finished;

    line_drawer #(.COORD_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .x        (x),
        .y        (y),
        .finished (finished)
    );

    typedef struct {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          fin;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (x !== e.x || y !== e.y || finished !== e.fin) begin
                miscompares++;
                $display("FAIL pixel t=%0t got (%0d,%0d) fin=%0b, expected (%0d,%0d) fin=%0b",
                         $time, x, y, finished, e.x, e.y, e.fin);
            end
        end
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic exp_t mk(input int px, input int py, input bit fin);
        exp_t e;
        e.x   = CW'(px);
        e.y   = CW'(py);
        e.fin = fin;
        return e;
    endfunction

    // Reference line: textbook integer Bresenham on plain ints, start to end inclusive.
    task automatic build_line(input int ax0, input int ay0, input int ax1, input int ay1,
                              output exp_t seq[$]);
        int dx, dy, sx, sy, err, e2, cx, cy;
        dx  = iabs(ax1 - ax0);
        dy  = -iabs(ay1 - ay0);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        cx  = ax0;
        cy  = ay0;
        seq = {};
        seq.push_back(mk(ax0, ay0, 1'b0));
        forever begin
            seq.push_back(mk(cx, cy, 1'b0));
            if (cx == ax1 && cy == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; cx += sx; end
            if (e2 <= dx) begin err += dx; cy += sy; end
        end
        seq.push_back(mk(ax1, ay1, 1'b1));
        seq.push_back(mk(ax1, ay1, 1'b1));
    endtask

    // Called just after a rising edge. Pulses reset for one cycle with the new endpoints,
    // then runs `trunc` observed cycles (whole line when 0); at cycle chg_at the end point
    // inputs are scrambled, which must not affect the captured line.
    task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1,
                              input int trunc, input int chg_at);
        exp_t seq[$];
        int   run;
        exp_q.delete();
        x0    = CW'(ax0);
        y0    = CW'(ay0);
        x1    = CW'(ax1);
        y1    = CW'(ay1);
        reset = 1'b1;
        exp_q.push_back(mk(ax0, ay0, 1'b0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        build_line(ax0, ay0, ax1, ay1, seq);
        run = (trunc > 0 && trunc < seq.size()) ? trunc : seq.size();
        for (int i = 0; i < run; i++) exp_q.push_back(seq[i]);
        for (int c = 0; c < run; c++) begin
            @(posedge clk);
            #1;
            if (c == chg_at) begin
                x1 = CW'($urandom_range(0, (1 << CW) - 1));
                y1 = CW'($urandom_range(0, (1 << CW) - 1));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired, expected %0d queued pixels to drain", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        @(posedge clk);
        #1;
        start_line(0, 0, 30, 20, 0, -1);
        start_line(5, 7, 9, 7, 0, -1);
        start_line(10, 20, 8, 10, 0, -1);
        start_line(3, 3, 3, 3, 0, -1);
        start_line(0, 0, 30, 20, 11, -1);
        start_line(1, 1, 31, 21, 0, -1);
        start_line(2, 40, 25, 3, 0, 4);
        start_line(40, 9, 4, 9, 0, 0);
        start_line(0, $urandom_range(0, 2047), 2047, $urandom_range(0, 2047), 0, -1);
        start_line(2047, 2047, 0, 0, 0, -1);
        for (int t = 0; t < 14; t++) begin
            start_line($urandom_range(0, 63), $urandom_range(0, 63),
                       $urandom_range(0, 63), $urandom_range(0, 63),
                       0, (t % 3 == 0) ? int'($urandom_range(1, 20)) : -1);
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_drawer.md
# line_drawer

Draws one straight line segment by emitting one pixel coordinate per clock using integer Bresenham, valid in all octants. It is restarted by a reset pulse from its controller, such as the line animator. The controller then consumes `x`/`y` every cycle with its own pixel colour until `finished` rises. It has no frame-buffer interface of its own.

## Interface
- `COORD_W`, default 11: width of every coordinate port.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high. Restarts the drawer.
- `x0`, `y0` input, COORD_W bits: start point, unsigned.
- `x1`, `y1` input, COORD_W bits: end point, unsigned.
- `x`, `y` output, COORD_W bits: current pixel to plot.
- `finished` output, 1 bit: high once the end point has been emitted.

## Operation
- FSM states: LOAD, DRAW, DONE.
- **Reset** (asynchronous, active-high) forces:
  - state = LOAD, `finished` = 0;
  - internal point and error registers = 0.
- **LOAD:**
  - `x`/`y` are driven combinationally from `x0`/`y0`.
  - At the next edge, the block captures the endpoints and computes:
    - `dx = |x1-x0|`
    - `dy = -|y1-y0|`
    - `sx = +1` if `x0 < x1`, else -1
    - `sy = +1` if `y0 < y1`, else -1
    - `err = dx + dy`
  - It sets point = (`x0`,`y0`) and goes to DRAW.
- **Endpoint sampling:** endpoints are sampled only on the LOAD edge. Later input changes are ignored until the next reset.
- **DRAW:** `x`/`y` = point register.
  - If point == (`x1`,`y1`) as captured: go to DONE at the next edge.
  - Otherwise, per edge, with `e2 = 2*err`:
    - if `e2 >= dy`: `err += dy`, `x += sx`;
    - if `e2 <= dx`: `err += dx`, `y += sy`;
    - both conditions may apply in the same cycle.
- **DONE:**
  - `finished` = 1.
  - `x`/`y` hold the end point.
  - The block stays in DONE until reset.
- **Arithmetic widths:**
  - deltas are signed COORD_W+1 bits;
  - `err` and `e2` are signed COORD_W+3 bits, so there is no overflow at full-range lines.
  - Coordinates never leave the bounding box of the two endpoints, so no wrap-around occurs.
- **Pixel count:** the line has N = max(|x1-x0|, |y1-y0|) + 1 distinct pixels. (`x0`,`y0`) is presented twice: in LOAD and in the first DRAW cycle. Plotting it twice is harmless.
- **Degenerate line** (start == end): one DRAW cycle, then DONE.

## Timing
- Edge E1 is the first rising edge with `reset` low.
- **Release to E1:** state LOAD, output = (`x0`,`y0`), `finished` = 0.
- **After Ek, for k = 1..N:** output = pixel k-1 of the line.
- **After E(N+1):** `finished` = 1, output = (`x1`,`y1`).
- **Latency:**
  - N+1 edges from reset release to `finished`;
  - throughput one pixel per cycle.
- **Reset asserted mid-line or in DONE:**
  - immediately LOAD, `finished` = 0;
  - outputs follow `x0`/`y0` while in LOAD, including while `reset` is held.
- **Restart:** a one-cycle reset pulse is sufficient. The controller may change the endpoints in the same cycle as the pulse.

## Structure
- Package `line_drawer_pkg` holds:
  - `COORD_W` default constant (11);
  - the state enum type (LOAD, DRAW, DONE);
  - the signed error-width constant.
- Keep the block single-module. The per-step Bresenham update is small combinational logic inside it; no sub-module.
- All registers use asynchronous active-high reset to the values listed above.

## Test plan
- **Diagonal:** (0,0)->(30,20).
  - Pixels are emitted one per cycle, with x incrementing every cycle and y 20 times.
  - The point after E31 is (30,20).
  - `finished` rises after E32.
- **Horizontal:** (5,7)->(9,7).
  - Outputs after E1..E5 are (5,7),(6,7),(7,7),(8,7),(9,7).
  - `finished` is high after E6.
- **Reverse steep:** (10,20)->(8,10).
  - y decrements every cycle and x decrements twice.
  - The point after E11 is (8,10); `finished` is high after E12.
- **Degenerate:** (3,3)->(3,3).
  - Output after E1 is (3,3).
  - `finished` is high after E2.
- **Reset mid-line:**
  - Assert `reset` after E10 of the (0,0)->(30,20) line, with new endpoints (1,1)->(31,21).
  - `finished` = 0 immediately and output = (1,1).
  - `finished` rises after E32 counted from the new release.
- **Endpoint change mid-draw:**
  - Change `x1` during DRAW.
  - The line still ends at the captured endpoint and `finished` timing is unchanged.
